// File: rtl/activity_tracker_core.sv
// activity_tracker_core
//   Pedometer core. Synchronises the raw step sensor, counts total steps, steps
//   per second, "fast" seconds inside an opening window and credited
//   high-activity time. A display FSM rotates these values over a 4-digit,
//   5-bit-per-digit bus.
//   Optional feature macro: TRACKER_PEAK_EN adds a PEAK page that shows the
//   highest per-second step count seen at any tick.
//   CNT_W must be at least 18 so that the display clamps and the distance slice fit.
// Ports
//   sys_clk   : system clock
//   reset     : asynchronous, active-high reset
//   step_in   : raw step sensor level, asynchronous to sys_clk
//   mode_hold : 1 freezes the display page and its tick counter
//   si        : total steps above 9999 (display saturated), registered
//   page      : current display page index
//   bcd       : {d3,d2,d1,d0}, 5 bits each; 0-9 digit, 5'h1F separator
//
// Display FSM
//   state    | meaning
//   PG_STEPS | total steps, clamped to 9999
//   PG_DIST  | total>>10 as "dd_h" (half units, .5 shown as 5)
//   PG_FAST  | fast seconds counted inside the window
//   PG_HIGH  | credited high-activity seconds, clamped to 9999
//   PG_PEAK  | highest seconds count (TRACKER_PEAK_EN only)
module activity_tracker_core #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int CNT_W        = 20,
  parameter int FAST_THRESH  = 32,
  parameter int WINDOW_SEC   = 9,
  parameter int HIGH_THRESH  = 64,
  parameter int HIGH_MIN_SEC = 60,
  parameter int DISP_SEC     = 2
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        step_in,
  input  logic        mode_hold,
  output logic        si,
  output logic [2:0]  page,
  output logic [19:0] bcd
);

  localparam int PS_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int WIN_W = $clog2(WINDOW_SEC + 1);
  localparam int DC_W  = (DISP_SEC > 1) ? $clog2(DISP_SEC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] DISP_MAX = CNT_W'(9999);
  localparam logic [CNT_W-1:0] HM       = CNT_W'(HIGH_MIN_SEC);
  localparam logic [CNT_W:0]   HM_EXT   = (CNT_W+1)'(HIGH_MIN_SEC);

  typedef enum logic [2:0] {
    PG_STEPS = 3'd0,
    PG_DIST  = 3'd1,
    PG_FAST  = 3'd2,
    PG_HIGH  = 3'd3,
    PG_PEAK  = 3'd4
  } page_t;

  logic             sync_a, sync_b, sync_c, step_p;
  logic [PS_W-1:0]  presc;
  logic             tick;
  logic [CNT_W-1:0] total, run, accum, run_n, accum_nxt;
  logic [CNT_W:0]   accum_sum, accum_add;
  logic [7:0]       sec_cnt;
  logic [WIN_W-1:0] win_cnt, fast_cnt;
  logic             sec_fast, sec_high;
  page_t            state, state_nxt;
  logic [DC_W-1:0]  dcnt, dcnt_nxt;
  logic [CNT_W-11:0] half, dist_hh;
  logic [6:0]       dist_int;
  logic [13:0]      disp_bin;
  logic [15:0]      dec;
  logic [19:0]      bcd_nxt;

  // Step synchroniser; step_p is registered so it is clean for the counters.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      sync_c <= 1'b0;
      step_p <= 1'b0;
    end else begin
      sync_a <= step_in;
      sync_b <= sync_a;
      sync_c <= sync_b;
      step_p <= sync_b & ~sync_c;
    end
  end

  assign tick = (presc == PS_W'(CLK_HZ - 1));

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) presc <= '0;
    else       presc <= tick ? '0 : presc + 1'b1;
  end

  assign sec_fast = (sec_cnt >  8'(FAST_THRESH));
  assign sec_high = (sec_cnt >= 8'(HIGH_THRESH));
  assign run_n    = (run == CNT_MAX) ? run : run + 1'b1;

  always_comb begin
    accum_add = '0;
    if (run_n == HM)     accum_add = HM_EXT;
    else if (run_n > HM) accum_add = (CNT_W+1)'(1);
    accum_sum = {1'b0, accum} + accum_add;
    accum_nxt = accum_sum[CNT_W] ? CNT_MAX : accum_sum[CNT_W-1:0];
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      total    <= '0;
      sec_cnt  <= '0;
      win_cnt  <= '0;
      fast_cnt <= '0;
      run      <= '0;
      accum    <= '0;
    end else begin
      if (step_p && total != CNT_MAX) total <= total + 1'b1;
      if (tick) begin
        // A step landing on the tick belongs to the new second.
        sec_cnt <= {7'd0, step_p};
        if (win_cnt < WIN_W'(WINDOW_SEC)) begin
          win_cnt <= win_cnt + 1'b1;
          if (sec_fast) fast_cnt <= fast_cnt + 1'b1;
        end
        if (sec_high) begin
          run   <= run_n;
          accum <= accum_nxt;
        end else begin
          run <= '0;
        end
      end else if (step_p && sec_cnt != 8'hFF) begin
        sec_cnt <= sec_cnt + 1'b1;
      end
    end
  end

`ifdef TRACKER_PEAK_EN
  logic [7:0] peak;
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset)                       peak <= '0;
    else if (tick && sec_cnt > peak) peak <= sec_cnt;
  end
`endif

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state <= PG_STEPS;
      dcnt  <= '0;
    end else begin
      state <= state_nxt;
      dcnt  <= dcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dcnt_nxt  = dcnt;
    if (tick && !mode_hold) begin
      if (dcnt == DC_W'(DISP_SEC - 1)) begin
        dcnt_nxt = '0;
        case (state)
          PG_STEPS: state_nxt = PG_DIST;
          PG_DIST:  state_nxt = PG_FAST;
          PG_FAST:  state_nxt = PG_HIGH;
`ifdef TRACKER_PEAK_EN
          PG_HIGH:  state_nxt = PG_PEAK;
`else
          PG_HIGH:  state_nxt = PG_STEPS;
`endif
          default:  state_nxt = PG_STEPS;
        endcase
      end else begin
        dcnt_nxt = dcnt + 1'b1;
      end
    end
  end

  assign page = state;

  function automatic logic [13:0] clamp4(input logic [CNT_W-1:0] v);
    return (v > DISP_MAX) ? 14'd9999 : v[13:0];
  endfunction

  // Shift-and-add-3 conversion of a value up to 9999.
  function automatic logic [15:0] bin2bcd(input logic [13:0] bin);
    logic [29:0] sh;
    sh = {16'd0, bin};
    for (int i = 0; i < 14; i++) begin
      for (int d = 0; d < 4; d++) begin
        if (sh[14+4*d +: 4] >= 4'd5) sh[14+4*d +: 4] = sh[14+4*d +: 4] + 4'd3;
      end
      sh = sh << 1;
    end
    return sh[29:14];
  endfunction

  assign half     = total[CNT_W-1:10];
  assign dist_hh  = half >> 1;
  assign dist_int = (dist_hh > (CNT_W-10)'(99)) ? 7'd99 : 7'(dist_hh);

  always_comb begin
    disp_bin = '0;
    case (state)
      PG_STEPS: disp_bin = clamp4(total);
      PG_DIST:  disp_bin = {7'd0, dist_int};
      PG_FAST:  disp_bin = 14'(fast_cnt);
      PG_HIGH:  disp_bin = clamp4(accum);
`ifdef TRACKER_PEAK_EN
      PG_PEAK:  disp_bin = {6'd0, peak};
`endif
      default:  disp_bin = '0;
    endcase
    dec     = bin2bcd(disp_bin);
    bcd_nxt = {1'b0, dec[15:12], 1'b0, dec[11:8], 1'b0, dec[7:4], 1'b0, dec[3:0]};
    // Distance reuses the two low decimal digits, then separator and half digit.
    if (state == PG_DIST)
      bcd_nxt = {1'b0, dec[7:4], 1'b0, dec[3:0], 5'h1F, half[0] ? 5'd5 : 5'd0};
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      bcd <= '0;
      si  <= 1'b0;
    end else begin
      bcd <= bcd_nxt;
      si  <= (total > DISP_MAX);
    end
  end

endmodule
